// File: rtl/lsu_writeback.sv
// Load/store/writeback stage: IDLE/BUSY/DONE sequencer in front of a 2^ADDR_W-word data RAM.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of forcing alignment.
module lsu_writeback #(
  parameter int ADDR_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        MemWrite,
  input  logic        ResultSrc,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        busy,
  output logic [31:0] Result,
  output logic        result_valid,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  // Stores only know SB/SH; loads additionally decode the unsigned byte/half codes.
  function automatic logic [1:0] acc_size(input logic [2:0] f3, input logic is_store);
    logic [1:0] sz;
    if (is_store) begin
      case (f3)
        3'b000:  sz = SZ_B;
        3'b001:  sz = SZ_H;
        default: sz = SZ_W;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: sz = SZ_B;
        3'b001, 3'b101: sz = SZ_H;
        default:        sz = SZ_W;
      endcase
    end
    return sz;
  endfunction

  function automatic logic [1:0] align_off(input logic [1:0] sz, input logic [1:0] a);
    logic [1:0] off;
    case (sz)
      SZ_B:    off = a;
      SZ_H:    off = {a[1], 1'b0};
      default: off = 2'b00;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b100:  r = {24'd0, sh[7:0]};
      3'b101:  r = {16'd0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] mask;
    logic [31:0] data;
    case (sz)
      SZ_B: begin
        mask = 32'h0000_00FF << {off, 3'b000};
        data = {4{wd[7:0]}};
      end
      SZ_H: begin
        mask = 32'h0000_FFFF << {off, 3'b000};
        data = {2{wd[15:0]}};
      end
      default: begin
        mask = 32'hFFFF_FFFF;
        data = wd;
      end
    endcase
    return (old & ~mask) | (data & mask);
  endfunction

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        f3_q, f3_d;
  logic              we_q, we_d;
  logic              ld_q, ld_d;
  logic              busy_q, busy_d;
  logic [31:0]       result_q, result_d;
  logic              rv_q, rv_d;
  logic              mis_q, mis_d;
  logic [31:0]       mem [0:(1 << ADDR_W) - 1];

  logic [ADDR_W-1:0] idx_s;
  logic [1:0]        off_s;
  logic              commit_s;
  logic              trap_s;

  assign idx_s    = addr_q[ADDR_W+1:2];
  assign off_s    = align_off(acc_size(f3_q, we_q), addr_q[1:0]);
  assign commit_s = (state_q == BUSY) && (cnt_q == 4'd0);

`ifdef LSU_MISALIGN_TRAP_EN
  logic [1:0] sz_in_s;
  assign sz_in_s = acc_size(funct3, MemWrite);
  assign trap_s  = (MemWrite | ResultSrc) &&
                   (((sz_in_s == SZ_H) && ALUResult[0]) ||
                    ((sz_in_s == SZ_W) && (ALUResult[1:0] != 2'b00)));
`else
  assign trap_s  = 1'b0;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    f3_d     = f3_q;
    we_d     = we_q;
    ld_d     = ld_q;
    result_d = result_q;
    rv_d     = 1'b0;
    mis_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = ALUResult;
          wdata_d = WriteData;
          f3_d    = funct3;
          we_d    = MemWrite;
          ld_d    = ResultSrc;
          if (!MemWrite && !ResultSrc) begin
            state_d  = DONE;
            rv_d     = 1'b1;
            result_d = ALUResult;
          end else if (trap_s) begin
            state_d  = DONE;
            rv_d     = 1'b1;
            mis_d    = 1'b1;
            result_d = 32'd0;
          end else begin
            state_d = BUSY;
            cnt_d   = LAT_M1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          rv_d    = 1'b1;
          if (we_q || !ld_q) begin
            result_d = addr_q;
          end else begin
            result_d = load_fmt(mem[idx_s], f3_q, off_s);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    busy_d = (state_d == BUSY);
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      f3_q     <= 3'd0;
      we_q     <= 1'b0;
      ld_q     <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= 32'd0;
      rv_q     <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      f3_q     <= f3_d;
      we_q     <= we_d;
      ld_q     <= ld_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      mis_q    <= mis_d;
    end
  end

  // Data RAM: deliberately outside reset so contents survive it; commits only on the last BUSY cycle.
  always_ff @(posedge clk) begin
    if (commit_s && we_q) begin
      mem[idx_s] <= store_merge(mem[idx_s], wdata_q, acc_size(f3_q, 1'b1), off_s);
    end
  end

  assign busy         = busy_q;
  assign Result       = result_q;
  assign result_valid = rv_q;
  assign misalign_err = mis_q;

endmodule
